// File: rtl/lcd_number_writer.sv
// lcd_number_writer
//   Converts a binary value to packed BCD with a serial shift-add-3 engine and
//   streams the digits, most-significant first, as ASCII characters to the
//   LCD character-write port over a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rstN       asynchronous active-low reset
//   start      conversion request, sampled only while idle
//   value      binary number, latched when start is accepted
//   startAddr  LCD address of the most-significant character, latched on start
//   charValid  charData/charAddr hold a character for the LCD driver
//   charData   ASCII character
//   charAddr   LCD address of charData
//   charReady  LCD driver takes the character on an edge where charValid=1
//   busy       high whenever not idle
//   done       one-cycle pulse after the last character transfer
module lcd_number_writer #(
  parameter int VALUE_WIDTH   = 10,
  parameter int BCD_DIGITS    = 3,
  parameter int BLANK_LEADING = 1
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic [6:0]             startAddr,
  output logic                   charValid,
  output logic [7:0]             charData,
  output logic [6:0]             charAddr,
  input  logic                   charReady,
  output logic                   busy,
  output logic                   done
);

  // state   | meaning
  // IDLE    | waiting for start
  // CONVERT | one double-dabble step per clock, VALUE_WIDTH steps
  // EMIT    | present characters MSD first, advance on each transfer
  // FINISH  | done pulse, then back to IDLE

  localparam int BW = 4 * BCD_DIGITS;
  localparam int CW = $clog2(VALUE_WIDTH + 1);
  localparam int IW = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;
  localparam logic [31:0] MAX_VAL = 32'(10 ** BCD_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, EMIT, FINISH} state_t;

  state_t                 state_q;
  logic [VALUE_WIDTH-1:0] value_q;
  logic [VALUE_WIDTH-1:0] shift_q;
  logic [BW-1:0]          bcd_q;
  logic [BW-1:0]          bcd_next;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic [6:0]             addr_q;
  logic                   overflow;

  // One double-dabble step: add 3 to every nibble >= 5, then shift the next
  // value bit in at the bottom. The carry out of the top nibble only occurs on
  // overflow, where the digits are replaced by '#' anyway.
  always_comb begin
    logic       carry;
    logic [3:0] nib;
    carry    = shift_q[VALUE_WIDTH-1];
    bcd_next = '0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      nib = bcd_q[4*d +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      bcd_next[4*d +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
  end

  assign overflow = 32'(value_q) > MAX_VAL;

  // Character for digit idx. A digit is blanked only when it and every digit
  // above it are zero; digit 0 always shows.
  function automatic logic [7:0] char_of(input logic [BW-1:0] bcd,
                                         input logic [IW-1:0] idx,
                                         input logic          ovf);
    logic       nz;
    logic [3:0] nib;
    logic [7:0] ch;
    nz  = 1'b0;
    nib = 4'd0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (IW'(d) >= idx && bcd[4*d +: 4] != 4'd0) nz = 1'b1;
      if (IW'(d) == idx) nib = bcd[4*d +: 4];
    end
    if (ovf)
      ch = 8'h23;
    else if (BLANK_LEADING != 0 && idx != '0 && !nz)
      ch = 8'h20;
    else
      ch = {4'h3, nib};
    return ch;
  endfunction

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      value_q   <= '0;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      charValid <= 1'b0;
      charData  <= 8'h00;
      charAddr  <= 7'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            value_q <= value;
            shift_q <= value;
            addr_q  <= startAddr;
            bcd_q   <= '0;
            cnt_q   <= CW'(VALUE_WIDTH);
            busy    <= 1'b1;
            state_q <= CONVERT;
          end
        end

        CONVERT: begin
          bcd_q   <= bcd_next;
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            idx_q   <= IW'(BCD_DIGITS - 1);
            state_q <= EMIT;
          end
        end

        EMIT: begin
          // First cycle in EMIT loads the MSD; afterwards each transfer loads
          // the next digit so characters follow back to back.
          if (!charValid) begin
            charValid <= 1'b1;
            charData  <= char_of(bcd_q, idx_q, overflow);
            charAddr  <= addr_q;
          end else if (charReady) begin
            if (idx_q == '0) begin
              charValid <= 1'b0;
              done      <= 1'b1;
              state_q   <= FINISH;
            end else begin
              idx_q    <= idx_q - IW'(1);
              charData <= char_of(bcd_q, idx_q - IW'(1), overflow);
              charAddr <= charAddr + 7'd1;
            end
          end
        end

        FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_number_writer.sv
module tb_lcd_number_writer;

  localparam int VW = 10;
  localparam int D  = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [VW-1:0] value;
  logic [6:0]    start_addr;
  logic          char_ready;
  logic          char_valid,  char_valid0;
  logic [7:0]    char_data,   char_data0;
  logic [6:0]    char_addr,   char_addr0;
  logic          busy,        busy0;
  logic          done,        done0;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_number_writer #(.VALUE_WIDTH(VW), .BCD_DIGITS(D), .BLANK_LEADING(1)) dut (
    .clk(clk), .rstN(rst_n), .start(start), .value(value), .startAddr(start_addr),
    .charValid(char_valid), .charData(char_data), .charAddr(char_addr),
    .charReady(char_ready), .busy(busy), .done(done)
  );

  lcd_number_writer #(.VALUE_WIDTH(VW), .BCD_DIGITS(D), .BLANK_LEADING(0)) dut0 (
    .clk(clk), .rstN(rst_n), .start(start), .value(value), .startAddr(start_addr),
    .charValid(char_valid0), .charData(char_data0), .charAddr(char_addr0),
    .charReady(char_ready), .busy(busy0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: k-th character sent (0 = most significant) for value v.
  function automatic int exp_char(input int v, input int k, input bit bl);
    int p;
    p = 10 ** (D - 1 - k);
    if (v > 10 ** D - 1) return 'h23;
    if (bl && k < D - 1 && v < p) return 'h20;
    return 'h30 + (v / p) % 10;
  endfunction

  // Entered #1 after an edge with the DUTs idle; returns #1 after the edge
  // that brings them back to idle, so a following call starts on the first
  // idle cycle after done.
  task automatic run_op(input int v, input int a, input bit rand_ready, input bit pulse_start);
    int cyc, nxfer, stall;
    logic [7:0] pd, pd0;
    logic [6:0] pa;
    logic       pv, pr;
    start      = 1'b1;
    value      = VW'(v);
    start_addr = 7'(a);
    char_ready = rand_ready ? 1'($urandom) : 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    value      = VW'($urandom);
    start_addr = 7'($urandom);
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (!char_valid && cyc < 200) begin
      start = (pulse_start && cyc == 3);
      if (start) value = VW'($urandom);
      if (rand_ready) char_ready = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("first_valid_latency", cyc, VW + 1);
    nxfer = 0; stall = 0; pv = 1'b0; pr = 1'b1; pd = '0; pd0 = '0; pa = '0;
    while (nxfer < D && cyc < 400) begin
      chk("valid_during_emit", char_valid, 1);
      chk("no_early_done", done, 0);
      if (pv && !pr) begin
        chk("stall_data_stable", char_data, pd);
        chk("stall_addr_stable", char_addr, pa);
      end
      if (rand_ready) begin
        if (nxfer == 1 && stall < 5) begin
          char_ready = 1'b0;
          stall++;
        end else begin
          char_ready = 1'($urandom);
        end
      end else begin
        char_ready = 1'b1;
      end
      start = pulse_start ? 1'($urandom) : 1'b0;
      if (start) value = VW'($urandom);
      pd = char_data; pd0 = char_data0; pa = char_addr; pr = char_ready; pv = 1'b1;
      @(posedge clk);
      if (pr) begin
        chk("char_data", pd, exp_char(v, nxfer, 1'b1));
        chk("char_data_noblank", pd0, exp_char(v, nxfer, 1'b0));
        chk("char_addr", pa, (a + nxfer) % 128);
        nxfer++;
      end
      #1;
      cyc++;
    end
    start = 1'b0;
    chk("transfer_count", nxfer, D);
    chk("done_pulse", done, 1);
    chk("valid_off_after_last", char_valid, 0);
    chk("busy_in_finish", busy, 1);
    if (!rand_ready) chk("start_to_done", cyc, VW + D + 1);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; value = '0; start_addr = '0; char_ready = 1'b0;
    #12;
    chk("rst_valid", char_valid, 0);
    chk("rst_data", char_data, 0);
    chk("rst_addr", char_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(123,  'h40, 1'b0, 1'b0);
    run_op(7,    'h40, 1'b0, 1'b0);
    run_op(0,    'h40, 1'b0, 1'b0);
    run_op(1000, 'h40, 1'b0, 1'b0);
    run_op(1023, 'h40, 1'b0, 1'b0);
    run_op(999,  'h40, 1'b0, 1'b0);
    run_op(456,  'h10, 1'b1, 1'b0);
    run_op(321,  'h7F, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++)
      run_op(int'($urandom_range(0, 1023)), int'($urandom_range(0, 127)),
             1'($urandom), 1'($urandom));

    // Reset while the second character is on the port.
    start = 1'b1; value = VW'(555); start_addr = 7'h20; char_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!char_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("pre_reset_valid", char_valid, 1);
    @(posedge clk); #1;
    chk("pre_reset_second_char", char_data, 'h35);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", char_valid, 0);
    chk("abort_data", char_data, 0);
    chk("abort_addr", char_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid_noblank", char_valid0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_no_done", done, 0);
    run_op(42, 'h05, 1'b0, 1'b0);
    run_op(int'($urandom_range(0, 1023)), 'h7E, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
